// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped cache tag controller, write-through.
// Ports: clk, reset (async, high); readFlag/writeFlag/flush requests with
// tag/index; mem_ack from memory. Outputs: stall, hit/miss pulses,
// mem_req/mem_we/mem_idx/mem_tag to memory, saturating hit/miss counts.
module cache_ctrl_dm #(
    parameter int TAG_W = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             readFlag,
    input  logic             writeFlag,
    input  logic             flush,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic             mem_ack,
    output logic             stall,
    output logic             hit,
    output logic             miss,
    output logic             mem_req,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [TAG_W-1:0] mem_tag,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_WAIT,
        S_FLUSH
    } state_t;

    state_t           r_state;
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0] r_tags [ENTRIES];
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_fidx;
    logic             r_op_we;
    logic             r_stall;
    logic             r_hit;
    logic             r_miss;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_match;

    // Table is only modified outside IDLE, so matching against the live
    // request at acceptance gives the same answer as matching in LOOKUP,
    // and lets hit/miss be registered pulses during the LOOKUP cycle.
    assign w_match = r_valid[index] && (r_tags[index] == tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            for (int i = 0; i < ENTRIES; i++) r_tags[i] <= '0;
            r_tag      <= '0;
            r_idx      <= '0;
            r_fidx     <= '0;
            r_op_we    <= 1'b0;
            r_stall    <= 1'b0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_hit  <= 1'b0;
                    r_miss <= 1'b0;
                    if (flush) begin
                        r_state <= S_FLUSH;
                        r_stall <= 1'b1;
                        r_fidx  <= '0;
                    end else if (writeFlag || readFlag) begin
                        r_state <= S_LOOKUP;
                        r_stall <= 1'b1;
                        r_tag   <= tag;
                        r_idx   <= index;
                        r_op_we <= writeFlag;
                        r_hit   <= w_match;
                        r_miss  <= !w_match;
                    end
                end
                S_LOOKUP: begin
                    r_hit  <= 1'b0;
                    r_miss <= 1'b0;
                    if (r_hit && (r_hit_cnt != {CNT_W{1'b1}}))
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    if (r_miss && (r_miss_cnt != {CNT_W{1'b1}}))
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    if (r_hit && !r_op_we) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end else begin
                        r_state   <= S_MEM_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= r_op_we;
                    end
                end
                S_MEM_WAIT: begin
                    // Read fill and write allocate both install the line.
                    if (mem_ack) begin
                        r_valid[r_idx] <= 1'b1;
                        r_tags[r_idx]  <= r_tag;
                        r_state        <= S_IDLE;
                        r_stall        <= 1'b0;
                        r_mem_req      <= 1'b0;
                        r_mem_we       <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_fidx] <= 1'b0;
                    r_fidx          <= r_fidx + 1'b1;
                    if (r_fidx == IDX_W'(ENTRIES - 1)) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign stall      = r_stall;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_idx    = r_idx;
    assign mem_tag    = r_tag;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb_cache_ctrl_dm: directed table, corner sequences and random traffic
// for cache_ctrl_dm, checked against a transaction-level cache model.
module tb_cache_ctrl_dm;

    logic       clk = 1'b0;
    logic       reset;
    logic       readFlag, writeFlag, flush, mem_ack;
    logic [7:0] tag;
    logic [2:0] index;

    logic       stall, hit, miss, mem_req, mem_we;
    logic [2:0] mem_idx;
    logic [7:0] mem_tag;
    logic [15:0] hit_count, miss_count;

    logic       stall2, hit2, miss2, mem_req2, mem_we2;
    logic [2:0] mem_idx2;
    logic [7:0] mem_tag2;
    logic [1:0] hit_count2, miss_count2;

    cache_ctrl_dm #(.TAG_W(8), .IDX_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .readFlag(readFlag),
        .writeFlag(writeFlag), .flush(flush), .tag(tag),
        .index(index), .mem_ack(mem_ack), .stall(stall), .hit(hit),
        .miss(miss), .mem_req(mem_req), .mem_we(mem_we),
        .mem_idx(mem_idx), .mem_tag(mem_tag),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_ctrl_dm #(.TAG_W(8), .IDX_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .readFlag(readFlag),
        .writeFlag(writeFlag), .flush(flush), .tag(tag),
        .index(index), .mem_ack(mem_ack), .stall(stall2), .hit(hit2),
        .miss(miss2), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_idx(mem_idx2), .mem_tag(mem_tag2),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the cache contents and lookup tallies.
    bit       m_valid [8];
    bit [7:0] m_tag   [8];
    int       m_hits;
    int       m_misses;

    typedef struct {
        bit       wr;
        bit [7:0] t;
        bit [2:0] i;
        bit       exp_hit;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input bit [7:0] t, input bit [2:0] i);
        return m_valid[i] && (m_tag[i] == t);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = 8'h00;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic chk_counts();
        chk("hit_count", 32'(hit_count), 32'(sat(m_hits, 65535)));
        chk("miss_count", 32'(miss_count), 32'(sat(m_misses, 65535)));
        chk("hit_count_sat", 32'(hit_count2), 32'(sat(m_hits, 3)));
        chk("miss_count_sat", 32'(miss_count2), 32'(sat(m_misses, 3)));
    endtask

    // One read or write transaction, from request through completion.
    task automatic access(input bit wr, input bit [7:0] t, input bit [2:0] i,
                          input bit exp_hit, input int dly, input bit junk);
        @(negedge clk);
        readFlag  = !wr;
        writeFlag = wr;
        tag       = t;
        index     = i;
        @(negedge clk);
        readFlag  = 1'b0;
        writeFlag = 1'b0;
        tag       = 8'($urandom);
        index     = 3'($urandom);
        chk("lookup_stall", 32'(stall), 32'd1);
        chk("lookup_hit", 32'(hit), 32'(exp_hit));
        chk("lookup_miss", 32'(miss), 32'(!exp_hit));
        if (exp_hit) m_hits++;
        else         m_misses++;
        @(negedge clk);
        chk("hit_clear", 32'(hit | miss), 32'd0);
        if (exp_hit && !wr) begin
            chk("hit_done_stall", 32'(stall), 32'd0);
            chk("hit_no_memreq", 32'(mem_req), 32'd0);
        end else begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(wr));
            chk("mem_idx", 32'(mem_idx), 32'(i));
            chk("mem_tag", 32'(mem_tag), 32'(t));
            for (int k = 0; k < dly; k++) begin
                if (junk) begin
                    readFlag  = 1'($urandom);
                    writeFlag = 1'($urandom);
                    flush     = 1'($urandom);
                end
                @(negedge clk);
                chk("mem_req_hold", 32'({mem_req, stall, mem_idx, mem_tag}),
                    32'({2'b11, i, t}));
            end
            readFlag  = 1'b0;
            writeFlag = 1'b0;
            flush     = 1'b0;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("ack_stall", 32'(stall), 32'd0);
            chk("ack_memreq", 32'({mem_req, mem_we}), 32'd0);
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
        end
        chk_counts();
    endtask

    vec_t vecs [5];
    int   cnt;
    bit   seen_pulse;
    bit   w;
    bit [7:0] rt;
    bit [2:0] ri;

    initial begin
        reset = 1'b1;
        readFlag = 1'b0; writeFlag = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        tag = 8'h00; index = 3'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs",
            32'({stall, hit, miss, mem_req, mem_we}), 32'd0);
        chk_counts();
        reset = 1'b0;

        // Directed sequence: read miss/hit, write-through allocate.
        vecs[0] = '{wr: 1'b0, t: 8'h5A, i: 3'd3, exp_hit: 1'b0};
        vecs[1] = '{wr: 1'b0, t: 8'h5A, i: 3'd3, exp_hit: 1'b1};
        vecs[2] = '{wr: 1'b1, t: 8'h11, i: 3'd3, exp_hit: 1'b0};
        vecs[3] = '{wr: 1'b0, t: 8'h11, i: 3'd3, exp_hit: 1'b1};
        vecs[4] = '{wr: 1'b0, t: 8'h5A, i: 3'd3, exp_hit: 1'b0};
        for (int v = 0; v < 5; v++)
            access(vecs[v].wr, vecs[v].t, vecs[v].i, vecs[v].exp_hit,
                   v, 1'b0);

        // Fill every index, then flush with a simultaneous read.
        for (int k = 0; k < 8; k++) begin
            rt = 8'h40 + 8'(k);
            access(1'b0, rt, 3'(k), model_hit(rt, 3'(k)), 1, 1'b0);
        end
        @(negedge clk);
        flush    = 1'b1;
        readFlag = 1'b1;
        tag      = 8'h40;
        index    = 3'd0;
        @(negedge clk);
        flush    = 1'b0;
        readFlag = 1'b0;
        cnt = 0;
        seen_pulse = 1'b0;
        while (stall && cnt < 20) begin
            if (hit || miss || mem_req) seen_pulse = 1'b1;
            cnt++;
            @(negedge clk);
        end
        chk("flush_cycles", 32'(cnt), 32'd8);
        chk("flush_no_pulse", 32'(seen_pulse), 32'd0);
        chk_counts();
        for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rt = 8'h40 + 8'(k);
            access(1'b0, rt, 3'(k), 1'b0, 0, 1'b0);
        end

        // Counter saturation on the narrow instance: five read hits.
        for (int k = 0; k < 5; k++)
            access(1'b0, 8'h47, 3'd7, 1'b1, 0, 1'b0);

        // Reset while waiting on memory, then a stray ack.
        @(negedge clk);
        readFlag = 1'b1;
        tag      = 8'h77;
        index    = 3'd5;
        @(negedge clk);
        readFlag = 1'b0;
        @(negedge clk);
        chk("pre_reset_memreq", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset",
            32'({stall, hit, miss, mem_req, mem_we}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_reset_idle",
            32'({stall, hit, miss, mem_req, mem_we}), 32'd0);
        chk_counts();
        access(1'b0, 8'h77, 3'd5, 1'b0, 0, 1'b0);
        access(1'b0, 8'h47, 3'd7, 1'b0, 0, 1'b0);

        // Random traffic with stray acks and ignored mid-flight requests.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                chk("stray_ack", 32'({stall, mem_req}), 32'd0);
            end
            w  = 1'($urandom);
            rt = 8'($urandom_range(0, 2));
            ri = 3'($urandom_range(0, 7));
            access(w, rt, ri, model_hit(rt, ri), $urandom_range(0, 3),
                   1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
